// File: rtl/mul_pipe_pkg.sv
// Multiplier opcode constants and the operand-signedness decode shared by the pipeline.
`include "defines.sv"

package mul_pipe_pkg;

  localparam logic [2:0] F3_MUL    = `FUNCT3_MUL;
  localparam logic [2:0] F3_MULH   = `FUNCT3_MULH;
  localparam logic [2:0] F3_MULHSU = `FUNCT3_MULHSU;
  localparam logic [2:0] F3_MULHU  = `FUNCT3_MULHU;

  // Returns {rs1_signed, rs2_signed}; any non-multiply encoding falls back to unsigned.
  function automatic logic [1:0] op_signs(input logic [2:0] funct3);
    logic [1:0] s;
    s = 2'b00;
    case (funct3)
      F3_MUL, F3_MULH: s = 2'b11;
      F3_MULHSU:       s = 2'b10;
      F3_MULHU:        s = 2'b00;
      default:         s = 2'b00;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mul_pipe_if.sv
// Issue, writeback, flush and bypass-lookup signals of the multiplier pipeline.
`include "defines.sv"

interface mul_pipe_if #(
  parameter int W  = `WORD_SIZE,
  parameter int RW = `ROB_ENTRY_WIDTH
);
  // valid/ready: a transfer happens on a rising clk edge where both are high;
  // the source holds its payload stable while valid is high and ready is low.
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic [2:0]    in_funct3;
  logic [RW-1:0] in_rob_id;
  logic [W-1:0]  in_pc;

  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_result;
  logic [RW-1:0] out_rob_id;
  logic [W-1:0]  out_pc;

  logic          flush;

  logic [RW-1:0] q1_rob_id;
  logic [RW-1:0] q2_rob_id;
  logic          q1_hit;
  logic          q2_hit;
  logic [W-1:0]  q1_data;
  logic [W-1:0]  q2_data;

  modport master (
    output in_valid, in_a, in_b, in_funct3, in_rob_id, in_pc,
    output out_ready, flush, q1_rob_id, q2_rob_id,
    input  in_ready, out_valid, out_result, out_rob_id, out_pc,
    input  q1_hit, q2_hit, q1_data, q2_data
  );

  modport slave (
    input  in_valid, in_a, in_b, in_funct3, in_rob_id, in_pc,
    input  out_ready, flush, q1_rob_id, q2_rob_id,
    output in_ready, out_valid, out_result, out_rob_id, out_pc,
    output q1_hit, q2_hit, q1_data, q2_data
  );
endinterface

// File: rtl/defines.sv
// Shared core-wide widths and the M-extension funct3 encodings used by the multiplier.
`ifndef MUL_PIPE_DEFINES_SV
`define MUL_PIPE_DEFINES_SV

`define WORD_SIZE        32
`define ROB_ENTRY_WIDTH  4

`define FUNCT3_MUL       3'b000
`define FUNCT3_MULH      3'b001
`define FUNCT3_MULHSU    3'b010
`define FUNCT3_MULHU     3'b011

`endif

// File: rtl/mul_pipe_slot.sv
// One pipeline stage register: clear drops the entry, load takes the upstream entry, else hold.
module mul_pipe_slot #(
  parameter int W  = 32,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic          clear_i,
  input  logic          valid_i,
  input  logic [RW-1:0] rob_id_i,
  input  logic [W-1:0]  pc_i,
  input  logic [W-1:0]  result_i,
  output logic          valid_o,
  output logic [RW-1:0] rob_id_o,
  output logic [W-1:0]  pc_o,
  output logic [W-1:0]  result_o
);

  logic          valid_q,  valid_d;
  logic [RW-1:0] rob_id_q, rob_id_d;
  logic [W-1:0]  pc_q,     pc_d;
  logic [W-1:0]  result_q, result_d;

  // Payload only moves with a real entry, so empty slots keep their last data.
  always_comb begin
    valid_d  = valid_q;
    rob_id_d = rob_id_q;
    pc_d     = pc_q;
    result_d = result_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = valid_i;
      if (valid_i) begin
        rob_id_d = rob_id_i;
        pc_d     = pc_i;
        result_d = result_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q  <= 1'b0;
      rob_id_q <= '0;
      pc_q     <= '0;
      result_q <= '0;
    end else begin
      valid_q  <= valid_d;
      rob_id_q <= rob_id_d;
      pc_q     <= pc_d;
      result_q <= result_d;
    end
  end

  assign valid_o  = valid_q;
  assign rob_id_o = rob_id_q;
  assign pc_o     = pc_q;
  assign result_o = result_q;

endmodule

// File: rtl/mul_pipe.sv
// RV32M multiply pipeline: product computed at entry, then carried through DEPTH
// bubble-collapsing stages with flush and a two-port ROB-id bypass lookup.
`include "defines.sv"

module mul_pipe
  import mul_pipe_pkg::*;
#(
  parameter int WORD_SIZE = `WORD_SIZE,
  parameter int DEPTH     = 4,
  parameter int ROB_W     = `ROB_ENTRY_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_SIZE-1:0] in_a,
  input  logic [WORD_SIZE-1:0] in_b,
  input  logic [2:0]           in_funct3,
  input  logic [ROB_W-1:0]     in_rob_id,
  input  logic [WORD_SIZE-1:0] in_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] out_result,
  output logic [ROB_W-1:0]     out_rob_id,
  output logic [WORD_SIZE-1:0] out_pc,
  input  logic                 flush,
  input  logic [ROB_W-1:0]     q1_rob_id,
  input  logic [ROB_W-1:0]     q2_rob_id,
  output logic                 q1_hit,
  output logic                 q2_hit,
  output logic [WORD_SIZE-1:0] q1_data,
  output logic [WORD_SIZE-1:0] q2_data
);

  localparam int W = WORD_SIZE;

  logic [DEPTH-1:0] slot_valid;
  logic [ROB_W-1:0] slot_rob [DEPTH];
  logic [W-1:0]     slot_pc  [DEPTH];
  logic [W-1:0]     slot_res [DEPTH];

  logic [DEPTH-1:0] src_valid;
  logic [ROB_W-1:0] src_rob [DEPTH];
  logic [W-1:0]     src_pc  [DEPTH];
  logic [W-1:0]     src_res [DEPTH];

  // room[i]: slot i is free or leaves this cycle; room[DEPTH] is the writeback sink.
  logic [DEPTH:0]   room;

  logic [1:0]             signs;
  logic [W:0]             a_ext, b_ext;
  logic signed [2*W+1:0]  prod;
  logic [W-1:0]           mul_res;
  logic                   unused_prod_hi;

  // Single combinational multiplier; one extra bit per operand covers all sign mixes.
  always_comb begin
    signs   = op_signs(in_funct3);
    a_ext   = {signs[1] & in_a[W-1], in_a};
    b_ext   = {signs[0] & in_b[W-1], in_b};
    prod    = $signed(a_ext) * $signed(b_ext);
    mul_res = (in_funct3 == F3_MUL) ? prod[W-1:0] : prod[2*W-1:W];
  end

  assign unused_prod_hi = ^prod[2*W+1:2*W];

  always_comb begin
    room[DEPTH] = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      room[i] = !slot_valid[i] || room[i+1];
    end
  end

  // Slot 0 is fed by the issue port, every other slot by its predecessor.
  always_comb begin
    src_valid[0] = in_valid && !flush;
    src_rob[0]   = in_rob_id;
    src_pc[0]    = in_pc;
    src_res[0]   = mul_res;
    for (int i = 1; i < DEPTH; i++) begin
      src_valid[i] = slot_valid[i-1];
      src_rob[i]   = slot_rob[i-1];
      src_pc[i]    = slot_pc[i-1];
      src_res[i]   = slot_res[i-1];
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    mul_pipe_slot #(
      .W  (W),
      .RW (ROB_W)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .load_i   (room[g]),
      .clear_i  (flush),
      .valid_i  (src_valid[g]),
      .rob_id_i (src_rob[g]),
      .pc_i     (src_pc[g]),
      .result_i (src_res[g]),
      .valid_o  (slot_valid[g]),
      .rob_id_o (slot_rob[g]),
      .pc_o     (slot_pc[g]),
      .result_o (slot_res[g])
    );
  end

  assign in_ready   = room[0];
  assign out_valid  = slot_valid[DEPTH-1];
  assign out_result = slot_res[DEPTH-1];
  assign out_rob_id = slot_rob[DEPTH-1];
  assign out_pc     = slot_pc[DEPTH-1];

  // ROB ids are unique in flight, so at most one slot matches each port.
  always_comb begin
    q1_hit  = 1'b0;
    q1_data = '0;
    q2_hit  = 1'b0;
    q2_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_valid[i] && (slot_rob[i] == q1_rob_id)) begin
        q1_hit  = 1'b1;
        q1_data = slot_res[i];
      end
      if (slot_valid[i] && (slot_rob[i] == q2_rob_id)) begin
        q2_hit  = 1'b1;
        q2_data = slot_res[i];
      end
    end
  end

endmodule

// File: doc/mul_pipe.md
MUL_PIPE -- requirements
Module: mul_pipe

Interface
REQ-001 SHALL have parameter WORD_SIZE, default `WORD_SIZE, operand and result width.
REQ-002 SHALL have parameter DEPTH, default 4, number of pipeline stages; legal range 2..8.
REQ-003 SHALL have parameter ROB_W, default `ROB_ENTRY_WIDTH, ROB id width.
REQ-004 SHALL have port clk  in  1  sole clock; all flops rise on posedge clk.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports in_valid in 1, in_ready out 1: issue handshake.
REQ-007 SHALL have ports in_a, in_b in WORD_SIZE: rs1/rs2 operands.
REQ-008 SHALL have port in_funct3 in 3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
REQ-009 SHALL have ports in_rob_id in ROB_W and in_pc in WORD_SIZE: tag and PC carried with the op.
REQ-010 SHALL have ports out_valid out 1, out_ready in 1, out_result out WORD_SIZE, out_rob_id out ROB_W, out_pc out WORD_SIZE: writeback handshake.
REQ-011 SHALL have port flush in 1: exception squash of all in-flight ops.
REQ-012 SHALL have ports q1_rob_id, q2_rob_id in ROB_W; q1_hit, q2_hit out 1; q1_data, q2_data out WORD_SIZE: decode bypass lookup.

Function
REQ-013 SHALL hold DEPTH stage slots (valid, rob_id, pc, result); slot 0 is entry, slot DEPTH-1 drives out_*.
REQ-014 SHALL compute the 2*WORD_SIZE product into slot 0 on acceptance; operand signedness: MUL/MULH signed x signed, MULHSU signed x unsigned, MULHU unsigned x unsigned.
REQ-015 SHALL select the low WORD_SIZE bits for MUL and the high WORD_SIZE bits otherwise; the result is final from slot 0 onward.
REQ-016 SHALL accept an op when in_valid && in_ready; latency from acceptance to out_valid is DEPTH-1 cycles when never back-pressured.
REQ-017 SHALL advance slot i into slot i+1 when slot i+1 is empty or itself advances; slot DEPTH-1 advances (retires) when out_ready is high.
REQ-018 SHALL collapse bubbles: a valid slot moves forward whenever the next slot frees, including while out_ready is low.
REQ-019 SHALL drive in_ready = !slot0.valid || slot0 advances (combinational, no dependence on in_valid).
REQ-020 SHALL drive out_valid = slot[DEPTH-1].valid; out_* remain stable while out_valid && !out_ready.
REQ-021 SHALL on flush clear every slot valid at the next edge, ignore a same-cycle issue, and force in_ready high the following cycle.
REQ-022 SHALL drive qN_hit when any valid slot holds rob_id == qN_rob_id, with qN_data that slot's result; ROB ids are unique in flight, so at most one slot matches.
REQ-023 SHALL drive qN_hit low during flush-cycle? No: qN_hit reflects current slot contents in all cycles, including the flush cycle.
REQ-024 SHALL with all slots full and out_ready low hold all state and drive in_ready low.
REQ-025 SHALL with all slots full and out_ready high accept a new op the same cycle (full throughput).

Reset
REQ-026 SHALL on rst low clear all slot valid bits asynchronously; out_valid=0, in_ready=1, q1_hit=q2_hit=0.
REQ-027 SHALL reset data fields (result, rob_id, pc) to 0; the first rising clk after rst deasserts may accept an op.

Structure
REQ-028 SHALL take WORD_SIZE, ROB_ENTRY_WIDTH and the funct3 MUL encodings from defines.sv; no new package types.
REQ-029 SHALL implement one sub-module mul_pipe_slot (one stage register with load/clear/hold), instantiated DEPTH times via generate.
REQ-030 SHALL keep the multiplier a single combinational block feeding slot 0; no retiming across slots.

Verification
REQ-031 SHALL test DEPTH=4, MUL 7*6, rob_id 3, out_ready=1 -> out_valid 3 cycles later, result 42, rob_id 3.
REQ-032 SHALL test MULH 0xFFFFFFFF*0xFFFFFFFF -> 0; MULHU same operands -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*2 -> 0xFFFFFFFF.
REQ-033 SHALL test issue of ops at cycles 0 and 2, out_ready=0 for 6 cycles -> two ops packed in slots 3 and 2, in_ready=1; then in order after out_ready=1.
REQ-034 SHALL test four ops in flight, flush -> out_valid=0 next cycle, no further output, q hits drop.
REQ-035 SHALL test rob_id 5 in slot 1, q1_rob_id=5 -> q1_hit=1 and q1_data equal to the result; q2_rob_id=6 -> q2_hit=0.
REQ-036 SHALL test rst low mid-stream (three ops in flight) -> all outputs at reset values immediately, without a clock edge.
